// File: rtl/filt_sched_pkg.sv
// Shared definitions for the XADC-to-FIR sample sequencer.
// State codes for the scheduler FSM and the filter-select codes understood
// by the `filters` block (also used by the filters testbench).
package filt_sched_pkg;

  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_START = 2'd1;
  localparam logic [1:0] STATE_WAIT  = 2'd2;
  localparam logic [1:0] STATE_OUT   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = STATE_IDLE,
    ST_START = STATE_START,
    ST_WAIT  = STATE_WAIT,
    ST_OUT   = STATE_OUT
  } sched_state_t;

  localparam logic [1:0] FILT_SEL_LPF  = 2'b00;
  localparam logic [1:0] FILT_SEL_HPF  = 2'b01;
  localparam logic [1:0] FILT_SEL_BPF  = 2'b10;
  localparam logic [1:0] FILT_SEL_RSVD = 2'b11;

  // The reserved code is not a filter: it leaves the current selection alone.
  function automatic logic [1:0] apply_select(input logic [1:0] cur_sel,
                                               input logic [1:0] req_sel);
    logic [1:0] result;
    case (req_sel)
      FILT_SEL_LPF,
      FILT_SEL_HPF,
      FILT_SEL_BPF:  result = req_sel;
      FILT_SEL_RSVD: result = cur_sel;
      default:       result = cur_sel;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/filt_sched_ctrl_fifo.sv
// filt_smp_fifo: small synchronous sample FIFO (2**AW entries x DW bits).
// A push on a full FIFO is accepted only if a pop happens in the same cycle.
// dout always shows the head entry, so it is valid in the cycle pop is asserted.
module filt_smp_fifo #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] dout
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          push_ok;
  logic          pop_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  // Work out which transfers actually happen and advance the pointers.
  always_comb begin
    pop_ok   = pop & ~empty;
    push_ok  = push & (~full | pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/filt_sched_ctrl.sv
// filt_sched_ctrl: sequencer between the XADC sample stream and the FIR block.
// Samples queue in a FIFO; each is held on filt_in while the filter runs, and
// the result is offered on a valid/ready port. Filter select changes only
// while idle between samples.
// Optional: define FILT_SEL_TIMEOUT_EN to add a WAIT watchdog (TIMEOUT cycles)
// that emits a zero result and sets tmo_flag; otherwise tmo_flag is tied 0.
module filt_sched_ctrl
  import filt_sched_pkg::*;
#(
  parameter int XADC_DATA_SIZE = 16,
  parameter int FIFO_AW        = 3,
  parameter int START_LEN      = 2
`ifdef FILT_SEL_TIMEOUT_EN
  ,
  parameter int TIMEOUT        = 1024
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      smp_valid,
  input  logic [XADC_DATA_SIZE-1:0] smp_data,
  input  logic [1:0]                cfg_select,
  output logic                      filt_start,
  output logic [1:0]                filt_select,
  output logic [XADC_DATA_SIZE-1:0] filt_in,
  input  logic [XADC_DATA_SIZE-1:0] filt_result,
  input  logic                      filt_done,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [XADC_DATA_SIZE-1:0] res_data,
  output logic                      ovf_flag,
  output logic                      tmo_flag
);

  localparam int CW = (START_LEN > 1) ? $clog2(START_LEN) : 1;
  localparam logic [CW-1:0] START_LAST = CW'(START_LEN - 1);

  sched_state_t              state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      done_q;
  logic [XADC_DATA_SIZE-1:0] filt_in_q, filt_in_d;
  logic [1:0]                sel_q, sel_d;
  logic [XADC_DATA_SIZE-1:0] res_data_q, res_data_d;
  logic                      ovf_q, ovf_d;
  logic                      done_rise;

  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [XADC_DATA_SIZE-1:0] fifo_dout;

`ifdef FILT_SEL_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wd_q, wd_d;
  logic        tmo_q, tmo_d;
`endif

  filt_smp_fifo #(
    .DW(XADC_DATA_SIZE),
    .AW(FIFO_AW)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (smp_valid),
    .din  (smp_data),
    .pop  (fifo_pop),
    .full (fifo_full),
    .empty(fifo_empty),
    .dout (fifo_dout)
  );

  assign done_rise   = filt_done & ~done_q;
  assign filt_start  = (state_q == ST_START);
  assign res_valid   = (state_q == ST_OUT);
  assign filt_in     = filt_in_q;
  assign filt_select = sel_q;
  assign res_data    = res_data_q;
  assign ovf_flag    = ovf_q;
`ifdef FILT_SEL_TIMEOUT_EN
  assign tmo_flag    = tmo_q;
`else
  assign tmo_flag    = 1'b0;
`endif

  // Scheduler FSM next-state, datapath captures and sticky overflow flag.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    filt_in_d  = filt_in_q;
    sel_d      = sel_q;
    res_data_d = res_data_q;
    fifo_pop   = 1'b0;
`ifdef FILT_SEL_TIMEOUT_EN
    wd_d       = wd_q;
    tmo_d      = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        sel_d = apply_select(sel_q, cfg_select);
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          filt_in_d = fifo_dout;
          cnt_d     = '0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == START_LAST) begin
          state_d = ST_WAIT;
`ifdef FILT_SEL_TIMEOUT_EN
          wd_d    = '0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (done_rise) begin
          res_data_d = filt_result;
          state_d    = ST_OUT;
`ifdef FILT_SEL_TIMEOUT_EN
        end else if (wd_q == TMO_LAST) begin
          res_data_d = '0;
          tmo_d      = 1'b1;
          state_d    = ST_OUT;
        end else begin
          wd_d = wd_q + 1'b1;
`endif
        end
      end
      ST_OUT: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    ovf_d = ovf_q | (smp_valid & fifo_full & ~fifo_pop);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      filt_in_q  <= '0;
      sel_q      <= FILT_SEL_LPF;
      res_data_q <= '0;
      ovf_q      <= 1'b0;
`ifdef FILT_SEL_TIMEOUT_EN
      wd_q       <= '0;
      tmo_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= filt_done;
      filt_in_q  <= filt_in_d;
      sel_q      <= sel_d;
      res_data_q <= res_data_d;
      ovf_q      <= ovf_d;
`ifdef FILT_SEL_TIMEOUT_EN
      wd_q       <= wd_d;
      tmo_q      <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_filt_sched_ctrl.sv
// Testbench for filt_sched_ctrl: directed samples, a behavioural filter model,
// and a scoreboard of hand-computed results checked by an independent monitor.
// The filter model returns filt_in ^ {filt_select, 14'h0}.
// Define FILT_SEL_TIMEOUT_EN to build the watchdog variant (TIMEOUT=16).
module tb_filt_sched_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        smp_valid;
  logic [15:0] smp_data;
  logic [1:0]  cfg_select;
  logic        filt_start;
  logic [1:0]  filt_select;
  logic [15:0] filt_in;
  logic [15:0] filt_result;
  logic        filt_done;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        ovf_flag;
  logic        tmo_flag;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb[$];

  bit          model_en = 1'b1;
  int          done_delay = 10;
  bit          busy = 1'b0;
  int          mcnt = 0;
  logic        start_prev = 1'b0;
  logic [15:0] cap_in;
  logic [1:0]  cap_sel;

  always #5 clk = ~clk;

  filt_sched_ctrl #(
    .XADC_DATA_SIZE(16),
    .FIFO_AW(3),
    .START_LEN(2)
`ifdef FILT_SEL_TIMEOUT_EN
    ,
    .TIMEOUT(16)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .smp_valid  (smp_valid),
    .smp_data   (smp_data),
    .cfg_select (cfg_select),
    .filt_start (filt_start),
    .filt_select(filt_select),
    .filt_in    (filt_in),
    .filt_result(filt_result),
    .filt_done  (filt_done),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .ovf_flag   (ovf_flag),
    .tmo_flag   (tmo_flag)
  );

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one sample strobe; called and returns just after a rising edge.
  task automatic applyStimulus(input logic [15:0] s);
    smp_data  = s;
    smp_valid = 1'b1;
    @(posedge clk);
    #1;
    smp_valid = 1'b0;
  endtask

  task automatic waitIdle(input int maxc, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && !res_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: drain timeout, %0d results outstanding", name, sb.size());
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_res_valid"},   {31'd0, res_valid},   32'd0);
    checkOutput({tag, "_filt_start"},  {31'd0, filt_start},  32'd0);
    checkOutput({tag, "_filt_select"}, {30'd0, filt_select}, 32'd0);
    checkOutput({tag, "_filt_in"},     {16'd0, filt_in},     32'd0);
    checkOutput({tag, "_res_data"},    {16'd0, res_data},    32'd0);
    checkOutput({tag, "_ovf_flag"},    {31'd0, ovf_flag},    32'd0);
    checkOutput({tag, "_tmo_flag"},    {31'd0, tmo_flag},    32'd0);
  endtask

  // Behavioural FIR stand-in: raises filt_done done_delay cycles after start.
  initial begin
    filt_done   = 1'b0;
    filt_result = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      if (model_en) begin
        if (filt_start && !start_prev) begin
          busy      = 1'b1;
          mcnt      = 0;
          filt_done = 1'b0;
          cap_in    = filt_in;
          cap_sel   = filt_select;
        end else if (busy) begin
          mcnt++;
          if (mcnt == done_delay) begin
            checkOutput("filt_in_stable",     {16'd0, filt_in},     {16'd0, cap_in});
            checkOutput("filt_select_stable", {30'd0, filt_select}, {30'd0, cap_sel});
            filt_result = cap_in ^ {cap_sel, 14'h0};
            filt_done   = 1'b1;
            busy        = 1'b0;
          end
        end
      end
      start_prev = filt_start;
    end
  end

  // Scoreboard monitor: compares each accepted result and checks hold stability.
  logic        hold_pending = 1'b0;
  logic [15:0] hold_data;
  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      if (hold_pending) checkOutput("res_data_hold", {16'd0, res_data}, {16'd0, hold_data});
      if (res_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result: got 0x%0h, expected none", res_data);
        end else begin
          logic [15:0] exp_v;
          exp_v = sb.pop_front();
          checkOutput("res_data", {16'd0, res_data}, {16'd0, exp_v});
        end
        hold_pending = 1'b0;
      end else begin
        hold_pending = 1'b1;
        hold_data    = res_data;
      end
    end else begin
      hold_pending = 1'b0;
    end
  end

  // Start pulse width monitor.
  int run_len = 0;
  always @(negedge clk) begin
    if (filt_start) run_len++;
    else if (run_len != 0) begin
      checkOutput("start_width", run_len, 32'd2);
      run_len = 0;
    end
  end

  // Global time limit.
  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Directed test sequence.
  initial begin
    rst_n      = 1'b0;
    smp_valid  = 1'b0;
    smp_data   = 16'h0;
    cfg_select = 2'b00;
    res_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] basic sample");
    sb.push_back(16'd100);
    applyStimulus(16'd100);
    @(posedge clk);
    #1;
    checkOutput("t1_start",   {31'd0, filt_start}, 32'd1);
    checkOutput("t1_filt_in", {16'd0, filt_in},    32'd100);
    waitIdle(100, "t1");

    $display("[TB] back-pressure");
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(16'(200 + i));
      applyStimulus(16'(200 + i));
    end
    repeat (20) @(posedge clk);
    #1;
    checkOutput("t2_valid_held", {31'd0, res_valid}, 32'd1);
    res_ready = 1'b1;
    waitIdle(200, "t2");
    checkOutput("t2_ovf", {31'd0, ovf_flag}, 32'd0);

    $display("[TB] overflow");
    res_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) sb.push_back(16'(300 + i));
      applyStimulus(16'(300 + i));
    end
    checkOutput("t3_ovf", {31'd0, ovf_flag}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    res_ready = 1'b1;
    waitIdle(400, "t3");

    $display("[TB] filter select");
    sb.push_back(16'h0011);
    applyStimulus(16'h0011);
    repeat (5) @(posedge clk);
    #1;
    cfg_select = 2'b10;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t4_sel_hold", {30'd0, filt_select}, 32'd0);
    waitIdle(100, "t4a");
    @(posedge clk);
    #1;
    checkOutput("t4_sel_applied", {30'd0, filt_select}, 32'd2);
    sb.push_back(16'h8022);
    applyStimulus(16'h0022);
    waitIdle(100, "t4b");
    cfg_select = 2'b11;
    sb.push_back(16'h8033);
    applyStimulus(16'h0033);
    @(posedge clk);
    #1;
    checkOutput("t4_sel_rsvd", {30'd0, filt_select}, 32'd2);
    waitIdle(100, "t4c");
    cfg_select = 2'b01;
    sb.push_back(16'h4044);
    applyStimulus(16'h0044);
    waitIdle(100, "t4d");

    $display("[TB] reset mid-wait");
    cfg_select = 2'b00;
    model_en   = 1'b0;
    applyStimulus(16'h0055);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkAllZero("t5");
    filt_done = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      checkOutput("t5_no_result", {31'd0, res_valid},  32'd0);
      checkOutput("t5_no_start",  {31'd0, filt_start}, 32'd0);
    end
    filt_done = 1'b0;
    busy      = 1'b0;
    model_en  = 1'b1;
    @(posedge clk);
    #1;

`ifdef FILT_SEL_TIMEOUT_EN
    $display("[TB] watchdog");
    begin
      int  cyc;
      bit  seen;
      model_en  = 1'b0;
      res_ready = 1'b0;
      cyc       = 0;
      seen      = 1'b0;
      sb.push_back(16'h0000);
      applyStimulus(16'h0066);
      for (int i = 1; i <= 100; i++) begin
        @(posedge clk);
        #1;
        if (res_valid) begin
          cyc  = i;
          seen = 1'b1;
          break;
        end
      end
      checkOutput("t6_seen",     {31'd0, seen},     32'd1);
      checkOutput("t6_latency",  cyc,               32'd19);
      checkOutput("t6_res_data", {16'd0, res_data}, 32'd0);
      checkOutput("t6_tmo_flag", {31'd0, tmo_flag}, 32'd1);
      res_ready = 1'b1;
      waitIdle(50, "t6");
      model_en = 1'b1;
    end
`endif

    checkOutput("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
